face_template_writer: RTL and testbench

- Writer end of the face-template memory interface. Accepts a byte stream over a valid/ready handshake and stores DEPTH bytes into an internal template array.
- Exposes a combinational addr/data read port, identical in shape to the face ROM port, so the existing comparator reads a loaded template instead of a fixed ROM.
- Sits between the capture/UART front end and the matcher.

---
 rtl/face_pkg.sv | 15 +
 rtl/face_tmpl_mem.sv | 39 +++
 rtl/face_template_writer.sv | 96 +++++++++
 tb/tb_face_template_writer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/face_pkg.sv
// Shared types and defaults for the face-template writer and its memory.
package face_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FACE_DEPTH  = 16;
    localparam int FACE_DATA_W = 8;

    localparam logic [FACE_DATA_W-1:0] FACE_FILL = 8'h00;

endpackage

// File: rtl/face_tmpl_mem.sv
// Template storage: synchronous write and clear, combinational read.
// Reads beyond DEPTH return zero so the comparator sees a blank byte.
module face_tmpl_mem
    import face_pkg::*;
#(
    parameter int DEPTH  = FACE_DEPTH,
    parameter int DATA_W = FACE_DATA_W,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (clr) begin
            mem <= {DEPTH{DATA_W'(FACE_FILL)}};
        end else if (we && (wr_addr < LIMIT)) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < LIMIT) begin
            rd_data = mem[rd_addr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/face_template_writer.sv
// Loads DEPTH stream bytes into the template memory and serves them on a
// ROM-shaped read port. Define FACE_WR_CKSUM_EN to enable the running checksum.
module face_template_writer
    import face_pkg::*;
#(
    parameter int DEPTH  = FACE_DEPTH,
    parameter int DATA_W = FACE_DATA_W,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wr_count,
    output logic [DATA_W-1:0] cksum
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q;
    logic              accept;
    logic              restart;

    // abort wins over a same-cycle accept: that byte is dropped
    assign accept  = in_ready && in_valid && !abort;
    assign restart = start && (state_q != LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD: begin
                if (abort)                           state_d = IDLE;
                else if (accept && (count_q == LAST)) state_d = DONE;
            end
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = (state_q == LOAD);
        done     = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       count_q <= '0;
        else if (restart) count_q <= '0;
        else if (accept)  count_q <= count_q + 1'b1;
    end

    assign wr_count = count_q;

`ifdef FACE_WR_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    always_ff @(posedge clk) begin
        if (!rst_n)       cksum_q <= '0;
        else if (restart) cksum_q <= '0;
        else if (accept)  cksum_q <= cksum_q + in_data;
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

    face_tmpl_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .clr     (!rst_n),
        .we      (accept),
        .wr_addr (count_q),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_face_template_writer.sv
// Directed plus randomized bench for face_template_writer against a
// byte-array reference model of the load rules.
module tb_face_template_writer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [7:0] wr_count;
    logic [7:0] cksum;

    face_template_writer #(.DEPTH(16), .DATA_W(8), .ADDR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count),
        .cksum    (cksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model
    logic [7:0] ref_mem [DEPTH];
    bit         loading = 0;
    bit         ref_done = 0;
    int         ref_cnt = 0;
    logic [7:0] ref_sum = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_cksum();
`ifdef FACE_WR_CKSUM_EN
        return ref_sum;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check_outs(input string ctx);
        chk({ctx, ".in_ready"}, in_ready, loading);
        chk({ctx, ".busy"},     busy,     loading);
        chk({ctx, ".done"},     done,     ref_done);
        chk({ctx, ".wr_count"}, wr_count, ref_cnt);
        chk({ctx, ".cksum"},    cksum,    exp_cksum());
    endtask

    task automatic check_mem(input string ctx);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 8'(a);
            #1;
            chk({ctx, ".rd_data"}, rd_data, ref_mem[a]);
        end
    endtask

    // one clock: drive inputs, advance model, check outputs after the edge
    task automatic cyc(input logic v, input logic [7:0] d, input logic s,
                       input logic a, input logic r, input string ctx);
        in_valid = v; in_data = d; start = s; abort = a; rst_n = r;
        if (!r) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
            loading = 0; ref_done = 0; ref_cnt = 0; ref_sum = 8'h00;
        end else if (loading) begin
            if (a) begin
                loading = 0;
            end else if (v) begin
                ref_mem[ref_cnt] = d;
                ref_cnt++;
                ref_sum = ref_sum + d;
                if (ref_cnt == DEPTH) begin
                    loading = 0;
                    ref_done = 1;
                end
            end
        end else if (s) begin
            loading = 1; ref_done = 0; ref_cnt = 0; ref_sum = 8'h00;
        end
        @(posedge clk);
        #1;
        in_valid = 0; start = 0; abort = 0; rst_n = 1;
        check_outs(ctx);
    endtask

    initial begin
        int first_done;
        logic [7:0] ck_exp;

        // reset
        cyc(0, 8'h00, 0, 0, 0, "reset");
        cyc(0, 8'h00, 0, 0, 0, "reset");
        check_mem("reset");

        // 16 x 0x74 with valid held high
        cyc(0, 8'h00, 1, 0, 1, "start1");
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'h74, 0, 0, 1, "held");
        check_mem("held");
`ifdef FACE_WR_CKSUM_EN
        ck_exp = 8'h40;
`else
        ck_exp = 8'h00;
`endif
        chk("cksum_74", cksum, ck_exp);
        chk("count_16", wr_count, 8'd16);

        // start from DONE drops done on the same edge; toggled valid with a
        // start pulse in the middle that must be ignored
        cyc(0, 8'h00, 1, 0, 1, "restart");
        first_done = -1;
        for (int i = 0; i < 40 && first_done < 0; i++) begin
            cyc((i % 2) == 0, 8'($urandom), (i == 10), 0, 1, "toggle");
            if (done === 1'b1) first_done = i + 1;
        end
        chk("toggle_len", first_done, 31);
        check_mem("toggle");

        // reset mid-load after 8 accepts
        cyc(0, 8'h00, 1, 0, 1, "start3");
        for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0, 0, 1, "pre_rst");
        cyc(1, 8'h55, 0, 0, 0, "mid_rst");
        check_mem("mid_rst");

        // abort coincident with the 6th accept
        cyc(0, 8'h00, 1, 0, 1, "start4");
        for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0, 1, "pre_abort");
        cyc(1, 8'h06, 0, 1, 1, "abort");
        chk("abort_count", wr_count, 8'd5);
        rd_addr = 8'd5;
        #1;
        chk("abort_addr5", rd_data, 8'h00);
        check_mem("abort");
        cyc(0, 8'h00, 0, 1, 1, "idle_abort");

        // out-of-range reads
        rd_addr = 8'd16;
        #1;
        chk("rd_16", rd_data, 8'h00);
        rd_addr = 8'd255;
        #1;
        chk("rd_255", rd_data, 8'h00);

        // randomized loads with sporadic gaps, aborts and stray starts
        for (int l = 0; l < 4; l++) begin
            cyc(0, 8'h00, 1, 0, 1, "rnd_start");
            for (int i = 0; i < 60 && loading; i++)
                cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0,
                    ($urandom % 40) == 0, 1, "rnd");
            check_mem("rnd");
            for (int j = 0; j < 4; j++) begin
                rd_addr = 8'($urandom_range(16, 255));
                #1;
                chk("rd_oob", rd_data, 8'h00);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
